// File: rtl/ddr3_cmd_arbiter.sv
// ddr3_cmd_arbiter: shares the single DDR3MI user command/data interface between
// a write requester and a read requester. Whole transactions are granted
// round-robin; command, write-data and read-data phases are sequenced and beats
// counted. A watchdog aborts any transaction that stalls for TIMEOUT cycles.
// Ports:
//   I_dma_clk, I_rst                  : DDR3 user clock, async active-high reset
//   I_calib_done                      : new grants blocked while low
//   I_wr_req/addr/burst/data          : write request, sampled at grant
//   O_wr_ack/pop/done                 : write command accepted / beat consumed / last beat
//   I_rd_req/addr/burst               : read request, sampled at grant
//   O_rd_ack/valid/data/done          : read command accepted / registered read beats
//   O_err                             : sticky watchdog abort flag
//   I_cmd_ready, O_cmd, O_cmd_en,
//   O_app_burst_number, O_addr        : DDR3 command channel
//   I_wr_data_rdy, O_wr_data_en/end,
//   O_wr_data, O_wr_data_mask         : DDR3 write data channel
//   I_rd_data_valid, I_rd_data        : DDR3 read data channel
module ddr3_cmd_arbiter #(
    parameter int unsigned ADDR_WIDTH = 28,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                    I_dma_clk,
    input  logic                    I_rst,
    input  logic                    I_calib_done,
    input  logic                    I_wr_req,
    input  logic [ADDR_WIDTH-1:0]   I_wr_addr,
    input  logic [5:0]              I_wr_burst,
    input  logic [DATA_WIDTH-1:0]   I_wr_data,
    output logic                    O_wr_ack,
    output logic                    O_wr_pop,
    output logic                    O_wr_done,
    input  logic                    I_rd_req,
    input  logic [ADDR_WIDTH-1:0]   I_rd_addr,
    input  logic [5:0]              I_rd_burst,
    output logic                    O_rd_ack,
    output logic                    O_rd_valid,
    output logic [DATA_WIDTH-1:0]   O_rd_data,
    output logic                    O_rd_done,
    output logic                    O_err,
    input  logic                    I_cmd_ready,
    output logic [2:0]              O_cmd,
    output logic                    O_cmd_en,
    output logic [5:0]              O_app_burst_number,
    output logic [ADDR_WIDTH-1:0]   O_addr,
    input  logic                    I_wr_data_rdy,
    output logic                    O_wr_data_en,
    output logic                    O_wr_data_end,
    output logic [DATA_WIDTH-1:0]   O_wr_data,
    output logic [DATA_WIDTH/8-1:0] O_wr_data_mask,
    input  logic                    I_rd_data_valid,
    input  logic [DATA_WIDTH-1:0]   I_rd_data
);

    localparam int unsigned CNT_W = 7;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  CMD_WR = 3'b000;
    localparam logic [2:0]  CMD_RD = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        WR_DATA,
        RD_CMD,
        RD_WAIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last_rd;     // 1: most recent grant went to the read port
    logic [CNT_W-1:0]  beat_cnt;
    logic [WD_W-1:0]   wdog;
    logic              grant_wr;
    logic              grant_rd;
    logic              beat;
    logic              rd_beat;
    logic              last_beat;
    logic              timeout;

    assign last_beat      = (beat_cnt == CNT_W'(O_app_burst_number));
    assign O_wr_data_end  = O_wr_data_en;
    assign O_wr_data      = I_wr_data;
    assign O_wr_data_mask = '0;

    // State register
    always_ff @(posedge I_dma_clk or posedge I_rst) begin
        if (I_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, arbitration and combinational handshake strobes
    always_comb begin
        state_next   = state;
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;
        beat         = 1'b0;
        rd_beat      = 1'b0;
        timeout      = 1'b0;
        O_cmd_en     = 1'b0;
        O_wr_ack     = 1'b0;
        O_rd_ack     = 1'b0;
        O_wr_data_en = 1'b0;
        O_wr_pop     = 1'b0;
        O_wr_done    = 1'b0;
        case (state)
            IDLE: begin
                if (I_calib_done) begin
                    // On a tie the port that did not win last time goes first
                    if (I_wr_req && (!I_rd_req || last_rd)) begin
                        grant_wr   = 1'b1;
                        state_next = WR_CMD;
                    end else if (I_rd_req) begin
                        grant_rd   = 1'b1;
                        state_next = RD_CMD;
                    end
                end
            end
            WR_CMD: begin
                O_cmd_en = I_cmd_ready;
                if (I_cmd_ready) begin
                    O_wr_ack   = 1'b1;
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                O_wr_data_en = I_wr_data_rdy;
                O_wr_pop     = I_wr_data_rdy;
                beat         = I_wr_data_rdy;
                if (I_wr_data_rdy && last_beat) begin
                    O_wr_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            RD_CMD: begin
                O_cmd_en = I_cmd_ready;
                if (I_cmd_ready) begin
                    O_rd_ack   = 1'b1;
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                beat    = I_rd_data_valid;
                rd_beat = I_rd_data_valid;
                if (I_rd_data_valid && last_beat) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Watchdog only fires on a cycle with no progress of any kind
        if (state != IDLE && state_next == state && !beat && wdog == WD_W'(TIMEOUT - 1)) begin
            timeout    = 1'b1;
            state_next = IDLE;
        end
    end

    // Latched command, beat/watchdog counters, registered read path, error flag
    always_ff @(posedge I_dma_clk or posedge I_rst) begin
        if (I_rst) begin
            last_rd            <= 1'b1;
            O_cmd              <= '0;
            O_addr             <= '0;
            O_app_burst_number <= '0;
            beat_cnt           <= '0;
            wdog               <= '0;
            O_err              <= 1'b0;
            O_rd_valid         <= 1'b0;
            O_rd_done          <= 1'b0;
            O_rd_data          <= '0;
        end else begin
            if (grant_wr || grant_rd) begin
                last_rd            <= grant_rd;
                O_cmd              <= grant_rd ? CMD_RD : CMD_WR;
                O_addr             <= grant_rd ? I_rd_addr : I_wr_addr;
                O_app_burst_number <= grant_rd ? I_rd_burst : I_wr_burst;
                beat_cnt           <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (beat || state_next != state) begin
                wdog <= '0;
            end else if (state != IDLE) begin
                wdog <= wdog + WD_W'(1);
            end
            if (timeout) begin
                O_err <= 1'b1;
            end
            O_rd_valid <= rd_beat;
            O_rd_done  <= rd_beat && last_beat;
            if (rd_beat) begin
                O_rd_data <= I_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// tb_ddr3_cmd_arbiter: directed self-checking bench for ddr3_cmd_arbiter.
// Cycle k is the window after rising edge k; inputs are driven at edge+1 and
// outputs sampled at edge+2. The watchdog is shortened to 16 cycles.
module tb_ddr3_cmd_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;
    localparam int unsigned TO = 16;

    logic            I_dma_clk = 1'b0;
    logic            I_rst;
    logic            I_calib_done;
    logic            I_wr_req;
    logic [AW-1:0]   I_wr_addr;
    logic [5:0]      I_wr_burst;
    logic [DW-1:0]   I_wr_data;
    logic            O_wr_ack;
    logic            O_wr_pop;
    logic            O_wr_done;
    logic            I_rd_req;
    logic [AW-1:0]   I_rd_addr;
    logic [5:0]      I_rd_burst;
    logic            O_rd_ack;
    logic            O_rd_valid;
    logic [DW-1:0]   O_rd_data;
    logic            O_rd_done;
    logic            O_err;
    logic            I_cmd_ready;
    logic [2:0]      O_cmd;
    logic            O_cmd_en;
    logic [5:0]      O_app_burst_number;
    logic [AW-1:0]   O_addr;
    logic            I_wr_data_rdy;
    logic            O_wr_data_en;
    logic            O_wr_data_end;
    logic [DW-1:0]   O_wr_data;
    logic [DW/8-1:0] O_wr_data_mask;
    logic            I_rd_data_valid;
    logic [DW-1:0]   I_rd_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 I_dma_clk = ~I_dma_clk;

    ddr3_cmd_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .I_dma_clk          (I_dma_clk),
        .I_rst              (I_rst),
        .I_calib_done       (I_calib_done),
        .I_wr_req           (I_wr_req),
        .I_wr_addr          (I_wr_addr),
        .I_wr_burst         (I_wr_burst),
        .I_wr_data          (I_wr_data),
        .O_wr_ack           (O_wr_ack),
        .O_wr_pop           (O_wr_pop),
        .O_wr_done          (O_wr_done),
        .I_rd_req           (I_rd_req),
        .I_rd_addr          (I_rd_addr),
        .I_rd_burst         (I_rd_burst),
        .O_rd_ack           (O_rd_ack),
        .O_rd_valid         (O_rd_valid),
        .O_rd_data          (O_rd_data),
        .O_rd_done          (O_rd_done),
        .O_err              (O_err),
        .I_cmd_ready        (I_cmd_ready),
        .O_cmd              (O_cmd),
        .O_cmd_en           (O_cmd_en),
        .O_app_burst_number (O_app_burst_number),
        .O_addr             (O_addr),
        .I_wr_data_rdy      (I_wr_data_rdy),
        .O_wr_data_en       (O_wr_data_en),
        .O_wr_data_end      (O_wr_data_end),
        .O_wr_data          (O_wr_data),
        .O_wr_data_mask     (O_wr_data_mask),
        .I_rd_data_valid    (I_rd_data_valid),
        .I_rd_data          (I_rd_data)
    );

    task automatic cyc();
        @(posedge I_dma_clk);
        #1;
    endtask

    task automatic test_reset();
        I_rst = 1'b1;
        I_wr_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        repeat (2) @(posedge I_dma_clk);
        #2;
        n_cmp++;
        if ({O_cmd_en, O_wr_ack, O_rd_ack, O_wr_pop, O_wr_done, O_rd_valid, O_rd_done,
             O_err, O_wr_data_en, O_wr_data_end} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 0000000000",
                     {O_cmd_en, O_wr_ack, O_rd_ack, O_wr_pop, O_wr_done, O_rd_valid, O_rd_done,
                      O_err, O_wr_data_en, O_wr_data_end});
        end
        n_cmp++;
        if ({O_cmd, O_app_burst_number, O_addr} !== 37'b0) begin
            n_err++;
            $display("FAIL reset_cmd_regs: got cmd=%b burst=%0d addr=%h expected all 0",
                     O_cmd, O_app_burst_number, O_addr);
        end
        n_cmp++;
        if (O_rd_data !== 128'b0) begin
            n_err++;
            $display("FAIL reset_rd_data: got %h expected 0", O_rd_data);
        end
        n_cmp++;
        if (O_wr_data_mask !== 16'b0) begin
            n_err++;
            $display("FAIL reset_mask: got %h expected 0", O_wr_data_mask);
        end
        n_cmp++;
        if (O_wr_data !== 128'h1111_2222_3333_4444_5555_6666_7777_8888) begin
            n_err++;
            $display("FAIL reset_wr_passthru: got %h expected 11112222333344445555666677778888", O_wr_data);
        end
        cyc();
        I_rst = 1'b0;
    endtask

    task automatic test_write_basic();
        int  en_cnt = 0;
        int  done_cnt = 0;
        int  first_en = -1;
        int  last_en = -1;
        int  done_at = -1;
        int  strobe_bad = 0;
        int  data_bad = 0;
        logic adv = 1'b0;
        I_cmd_ready = 1'b1;
        I_wr_data_rdy = 1'b1;
        I_calib_done = 1'b1;
        cyc();
        I_wr_addr = 28'h0AB_CDE0;
        I_wr_burst = 6'd3;
        I_wr_data = 128'h100;
        I_wr_req = 1'b1;
        cyc(); #1;
        n_cmp++;
        if ({O_cmd_en, O_wr_ack, O_rd_ack, O_cmd} !== 6'b110000) begin
            n_err++;
            $display("FAIL wr_cmd_phase: got %b expected 110000", {O_cmd_en, O_wr_ack, O_rd_ack, O_cmd});
        end
        n_cmp++;
        if ({O_addr, O_app_burst_number} !== {28'h0AB_CDE0, 6'd3}) begin
            n_err++;
            $display("FAIL wr_latched: got addr=%h burst=%0d expected addr=0abcde0 burst=3", O_addr, O_app_burst_number);
        end
        I_wr_req = 1'b0;
        for (int c = 2; c < 10; c++) begin
            cyc();
            if (adv) I_wr_data = I_wr_data + 128'd1;
            adv = 1'b0;
            #1;
            if (O_wr_data_end !== O_wr_data_en || O_wr_pop !== O_wr_data_en || O_wr_ack) strobe_bad++;
            if (O_wr_data_en) begin
                if (first_en < 0) first_en = c;
                last_en = c;
                en_cnt++;
                if (O_wr_data !== DW'(32'h100 + en_cnt - 1)) data_bad++;
                adv = 1'b1;
            end
            if (O_wr_done) begin
                done_cnt++;
                done_at = c;
            end
        end
        n_cmp++;
        if (en_cnt != 4 || first_en != 2 || last_en != 5) begin
            n_err++;
            $display("FAIL wr_beats: got %0d beats cycles %0d..%0d expected 4 beats cycles 2..5", en_cnt, first_en, last_en);
        end
        n_cmp++;
        if (done_cnt != 1 || done_at != 5) begin
            n_err++;
            $display("FAIL wr_done: got %0d pulses last at %0d expected 1 at 5", done_cnt, done_at);
        end
        n_cmp++;
        if (strobe_bad != 0 || data_bad != 0) begin
            n_err++;
            $display("FAIL wr_strobes: got strobe_bad=%0d data_bad=%0d expected 0/0", strobe_bad, data_bad);
        end
    endtask

    task automatic test_read_single();
        logic [DW-1:0] k = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        int vcnt = 0;
        int vat = -1;
        int dcnt = 0;
        int dat = -1;
        logic [DW-1:0] vdata = '0;
        // stray beat while idle must be ignored
        cyc();
        I_rd_data_valid = 1'b1;
        I_rd_data = 128'hBAD;
        cyc();
        I_rd_data_valid = 1'b0;
        #1;
        n_cmp++;
        if (O_rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_stray_valid: got %b expected 0", O_rd_valid);
        end
        I_rd_addr = 28'h012_3450;
        I_rd_burst = 6'd0;
        I_rd_req = 1'b1;
        cyc(); #1;
        n_cmp++;
        if ({O_cmd_en, O_rd_ack, O_wr_ack, O_cmd, O_addr} !== {3'b110, 3'b001, 28'h012_3450}) begin
            n_err++;
            $display("FAIL rd_cmd_phase: got en=%b rack=%b wack=%b cmd=%b addr=%h expected 1 1 0 001 0123450",
                     O_cmd_en, O_rd_ack, O_wr_ack, O_cmd, O_addr);
        end
        I_rd_req = 1'b0;
        // beat returned 12 cycles after the command, inside the 16-cycle watchdog
        for (int c = 2; c < 19; c++) begin
            cyc();
            I_rd_data_valid = (c == 13);
            I_rd_data = (c == 13) ? k : ~k;
            #1;
            if (O_rd_valid) begin
                vcnt++;
                vat = c;
                vdata = O_rd_data;
            end
            if (O_rd_done) begin
                dcnt++;
                dat = c;
            end
        end
        I_rd_data_valid = 1'b0;
        n_cmp++;
        if (vcnt != 1 || vat != 14) begin
            n_err++;
            $display("FAIL rd_valid_timing: got %0d valids last at %0d expected 1 at 14", vcnt, vat);
        end
        n_cmp++;
        if (vdata !== k) begin
            n_err++;
            $display("FAIL rd_data: got %h expected %h", vdata, k);
        end
        n_cmp++;
        if (dcnt != 1 || dat != 14) begin
            n_err++;
            $display("FAIL rd_done: got %0d pulses at %0d expected 1 at 14", dcnt, dat);
        end
    endtask

    task automatic test_round_robin();
        int   ack_cyc[4] = '{-1, -1, -1, -1};
        int   exp_cyc[4] = '{1, 4, 7, 10};
        logic [3:0] kinds = 4'b0;
        int   n_ack = 0;
        int   overlap = 0;
        logic busy = 1'b0;
        logic rd_pend = 1'b0;
        I_cmd_ready = 1'b1;
        I_wr_data_rdy = 1'b1;
        I_calib_done = 1'b1;
        cyc();
        I_rst = 1'b1;
        cyc();
        I_rst = 1'b0;
        I_wr_addr = 28'h000_1000;
        I_wr_burst = 6'd0;
        I_rd_addr = 28'h000_2000;
        I_rd_burst = 6'd0;
        I_wr_req = 1'b1;
        I_rd_req = 1'b1;
        for (int c = 1; c < 15; c++) begin
            cyc();
            I_rd_data_valid = rd_pend;
            I_rd_data = DW'(c);
            rd_pend = 1'b0;
            #1;
            if (O_wr_done || O_rd_done) busy = 1'b0;
            if (O_wr_ack || O_rd_ack) begin
                if (busy) overlap++;
                if (n_ack < 4) begin
                    ack_cyc[n_ack] = c;
                    kinds[n_ack] = O_rd_ack;
                end
                n_ack++;
                busy = 1'b1;
                if (n_ack == 4) begin
                    I_wr_req = 1'b0;
                    I_rd_req = 1'b0;
                end
            end
            if (O_rd_ack) rd_pend = 1'b1;
        end
        I_rd_data_valid = 1'b0;
        n_cmp++;
        if (n_ack != 4 || kinds !== 4'b1010) begin
            n_err++;
            $display("FAIL rr_order: got %0d acks kinds(bit0 first)=%b expected 4 acks 1010 (W,R,W,R)", n_ack, kinds);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ack_cyc[i] != exp_cyc[i]) begin
                n_err++;
                $display("FAIL rr_ack_cycle%0d: got %0d expected %0d", i, ack_cyc[i], exp_cyc[i]);
            end
        end
        n_cmp++;
        if (overlap != 0) begin
            n_err++;
            $display("FAIL rr_overlap: got %0d acks before prior done expected 0", overlap);
        end
    endtask

    task automatic test_write_stall();
        int bad_en = 0;
        int en_cnt = 0;
        int ack_at = -1;
        int pops = 0;
        int bad_pop = 0;
        int done_cnt = 0;
        int done_at = -1;
        cyc();
        I_cmd_ready = 1'b0;
        I_wr_addr = 28'h0FF_0000;
        I_wr_burst = 6'd7;
        I_wr_req = 1'b1;
        for (int c = 1; c < 29; c++) begin
            cyc();
            I_cmd_ready = (c >= 6);
            I_wr_data_rdy = (c % 2 == 1);
            #1;
            if (O_cmd_en && !I_cmd_ready) bad_en++;
            if (O_cmd_en) en_cnt++;
            if (O_wr_ack) begin
                ack_at = c;
                I_wr_req = 1'b0;
            end
            if (O_wr_pop) pops++;
            if (O_wr_pop && !I_wr_data_rdy) bad_pop++;
            if (O_wr_done) begin
                done_cnt++;
                done_at = c;
            end
        end
        I_wr_data_rdy = 1'b1;
        n_cmp++;
        if (bad_en != 0 || en_cnt != 1 || ack_at != 6) begin
            n_err++;
            $display("FAIL stall_cmd_en: got bad=%0d strobes=%0d ack_at=%0d expected 0 1 6", bad_en, en_cnt, ack_at);
        end
        n_cmp++;
        if (pops != 8 || bad_pop != 0) begin
            n_err++;
            $display("FAIL stall_pops: got %0d pops (%0d without ready) expected 8 (0)", pops, bad_pop);
        end
        n_cmp++;
        if (done_cnt != 1 || done_at != 21) begin
            n_err++;
            $display("FAIL stall_done: got %0d pulses at %0d expected 1 at 21", done_cnt, done_at);
        end
    endtask

    task automatic test_timeout();
        int rd_ack_at = -1;
        int vcnt = 0;
        int dcnt = 0;
        int err_at = -1;
        int wr_ack_at = -1;
        int wr_done_at = -1;
        logic [2:0] cmd_at_wack = 3'b111;
        I_cmd_ready = 1'b1;
        I_wr_data_rdy = 1'b1;
        cyc();
        I_rd_addr = 28'h0C0_0000;
        I_rd_burst = 6'd3;
        I_rd_req = 1'b1;
        I_wr_addr = 28'h0D0_0000;
        I_wr_burst = 6'd0;
        for (int c = 1; c < 27; c++) begin
            cyc();
            I_rd_data_valid = (c == 3 || c == 4);
            I_rd_data = DW'(c);
            if (c == 3) I_wr_req = 1'b1;
            #1;
            if (O_rd_ack) begin
                rd_ack_at = c;
                I_rd_req = 1'b0;
            end
            if (O_rd_valid) vcnt++;
            if (O_rd_done) dcnt++;
            if (O_err && err_at < 0) err_at = c;
            if (O_wr_ack) begin
                wr_ack_at = c;
                cmd_at_wack = O_cmd;
                I_wr_req = 1'b0;
            end
            if (O_wr_done) wr_done_at = c;
        end
        I_rd_data_valid = 1'b0;
        n_cmp++;
        if (rd_ack_at != 1 || vcnt != 2 || dcnt != 0) begin
            n_err++;
            $display("FAIL to_read: got ack_at=%0d valids=%0d dones=%0d expected 1 2 0", rd_ack_at, vcnt, dcnt);
        end
        n_cmp++;
        if (err_at != 21) begin
            n_err++;
            $display("FAIL to_err_cycle: got %0d expected 21", err_at);
        end
        n_cmp++;
        if (wr_ack_at != 22 || cmd_at_wack !== 3'b000 || wr_done_at != 23) begin
            n_err++;
            $display("FAIL to_next_write: got ack_at=%0d cmd=%b done_at=%0d expected 22 000 23",
                     wr_ack_at, cmd_at_wack, wr_done_at);
        end
        n_cmp++;
        if (O_err !== 1'b1) begin
            n_err++;
            $display("FAIL to_err_sticky: got %b expected 1", O_err);
        end
    endtask

    task automatic test_reset_mid();
        int pops = 0;
        int dones = 0;
        int acks = 0;
        logic [AW-1:0] addr_at_ack = '0;
        cyc();
        I_wr_addr = 28'h0E0_0000;
        I_wr_burst = 6'd3;
        I_wr_req = 1'b1;
        for (int c = 1; c < 5; c++) begin
            cyc(); #1;
            if (O_wr_ack) I_wr_req = 1'b0;
            if (O_wr_pop) pops++;
            if (O_wr_done) dones++;
        end
        // third beat (counter 2) is on the bus now: pull reset mid-beat
        I_rst = 1'b1;
        #1;
        n_cmp++;
        if ({O_cmd_en, O_wr_pop, O_wr_data_en, O_wr_done, O_err, O_addr} !== {5'b0, 28'h0}) begin
            n_err++;
            $display("FAIL rstmid_outputs: got en=%b pop=%b wen=%b done=%b err=%b addr=%h expected all 0",
                     O_cmd_en, O_wr_pop, O_wr_data_en, O_wr_done, O_err, O_addr);
        end
        cyc(); #1;
        I_rst = 1'b0;
        if (O_wr_done) dones++;
        n_cmp++;
        if (pops != 3 || dones != 0) begin
            n_err++;
            $display("FAIL rstmid_abandon: got pops=%0d dones=%0d expected 3 0", pops, dones);
        end
        pops = 0;
        dones = 0;
        cyc();
        I_wr_addr = 28'h0E1_0000;
        I_wr_burst = 6'd1;
        I_wr_req = 1'b1;
        for (int c = 1; c < 9; c++) begin
            cyc(); #1;
            if (O_wr_ack) begin
                acks++;
                addr_at_ack = O_addr;
                I_wr_req = 1'b0;
            end
            if (O_wr_pop) pops++;
            if (O_wr_done) dones++;
        end
        n_cmp++;
        if (acks != 1 || pops != 2 || dones != 1 || addr_at_ack !== 28'h0E1_0000) begin
            n_err++;
            $display("FAIL rstmid_fresh_write: got acks=%0d pops=%0d dones=%0d addr=%h expected 1 2 1 0e10000",
                     acks, pops, dones, addr_at_ack);
        end
    endtask

    task automatic test_calib();
        int en_cnt = 0;
        int acks = 0;
        int pops = 0;
        int dones = 0;
        cyc();
        I_calib_done = 1'b0;
        I_wr_addr = 28'h0F0_0000;
        I_wr_burst = 6'd2;
        I_wr_req = 1'b1;
        I_rd_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc(); #1;
            if (O_cmd_en) en_cnt++;
            if (O_wr_ack || O_rd_ack) acks++;
        end
        n_cmp++;
        if (en_cnt != 0 || acks != 0) begin
            n_err++;
            $display("FAIL calib_block: got cmd_en=%0d acks=%0d expected 0 0", en_cnt, acks);
        end
        // calibration drops right after the ack; the transfer must still finish
        I_rd_req = 1'b0;
        I_calib_done = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc(); #1;
            if (O_wr_ack) begin
                acks++;
                I_calib_done = 1'b0;
                I_wr_req = 1'b0;
            end
            if (O_wr_pop) pops++;
            if (O_wr_done) dones++;
        end
        n_cmp++;
        if (acks != 1 || pops != 3 || dones != 1) begin
            n_err++;
            $display("FAIL calib_mid_txn: got acks=%0d pops=%0d dones=%0d expected 1 3 1", acks, pops, dones);
        end
    endtask

    initial begin
        I_rst = 1'b1;
        I_calib_done = 1'b0;
        I_wr_req = 1'b0;
        I_wr_addr = '0;
        I_wr_burst = '0;
        I_wr_data = '0;
        I_rd_req = 1'b0;
        I_rd_addr = '0;
        I_rd_burst = '0;
        I_cmd_ready = 1'b0;
        I_wr_data_rdy = 1'b0;
        I_rd_data_valid = 1'b0;
        I_rd_data = '0;
        test_reset();
        test_write_basic();
        test_read_single();
        test_round_robin();
        test_write_stall();
        test_timeout();
        test_reset_mid();
        test_calib();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
